// File: rtl/text_writer.sv
// text_writer
// Byte-stream text command engine feeding the video memory write port.
// Printable bytes become single-cycle masked cell writes at the cursor.
// Control codes handle cursor movement, attribute loading and a full-screen
// clear sequencer.
//
// Ports:
//   clk           : system clock
//   reset         : asynchronous active-high reset
//   in_data       : command / character byte
//   in_valid      : in_data valid
//   in_ready      : byte accepted when in_valid && in_ready at a rising edge
//   xcursor       : cursor column
//   ycursor       : cursor row
//   video_write   : one-cycle write strobe (registered)
//   video_address : cell index y*COLS + x (registered)
//   video_value   : cell word (registered)
//   video_mask    : bits to update, all ones once any write is issued

`ifndef TEXTCOLS_CHAR
`define TEXTCOLS_CHAR 80
`endif
`ifndef TEXTROWS_CHAR
`define TEXTROWS_CHAR 30
`endif
`ifndef TEXTCOLS_RANGE
`define TEXTCOLS_RANGE 6:0
`endif
`ifndef TEXTROWS_RANGE
`define TEXTROWS_RANGE 4:0
`endif
`ifndef CHARATTR_RANGE
`define CHARATTR_RANGE 23:0
`endif
`ifndef CHARATTR_INDEX
`define CHARATTR_INDEX 7:0
`endif

module text_writer #(
   parameter int                    COLS       = `TEXTCOLS_CHAR,
   parameter int                    ROWS       = `TEXTROWS_CHAR,
   parameter logic [`CHARATTR_RANGE] ATTR_RESET = '0
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [7:0]             in_data,
   input  logic                   in_valid,
   output logic                   in_ready,
   output logic [`TEXTCOLS_RANGE] xcursor,
   output logic [`TEXTROWS_RANGE] ycursor,
   output logic                   video_write,
   output logic [15:0]            video_address,
   output logic [`CHARATTR_RANGE] video_value,
   output logic [`CHARATTR_RANGE] video_mask
);

   localparam int XW = $bits(logic [`TEXTCOLS_RANGE]);
   localparam int YW = $bits(logic [`TEXTROWS_RANGE]);
   localparam int AW = $bits(logic [`CHARATTR_RANGE]);
   localparam int IW = $bits(logic [`CHARATTR_INDEX]);

   localparam logic [XW-1:0] X_MAX = XW'(COLS - 1);
   localparam logic [YW-1:0] Y_MAX = YW'(ROWS - 1);
   localparam logic [15:0]   CELLS = 16'(COLS * ROWS);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_GOTO_X = 3'd1,
      S_GOTO_Y = 3'd2,
      S_ATTR2  = 3'd3,
      S_ATTR1  = 3'd4,
      S_ATTR0  = 3'd5,
      S_CLEAR  = 3'd6
   } state_t;

   state_t          r_state, w_state_nxt;
   logic [XW-1:0]   r_x, w_x_nxt;
   logic [YW-1:0]   r_y, w_y_nxt;
   logic [XW-1:0]   r_goto_x, w_goto_x_nxt;
   logic [AW-1:0]   r_attr, w_attr_nxt;
   logic [15:0]     r_shadow, w_shadow_nxt;   // first two attribute bytes
   logic [15:0]     r_clr, w_clr_nxt;         // next cell to clear
   logic            r_wr, w_wr_nxt;
   logic [15:0]     r_addr, w_addr_nxt;
   logic [AW-1:0]   r_val, w_val_nxt;
   logic [AW-1:0]   r_mask, w_mask_nxt;

   logic            w_accept;
   logic [15:0]     w_cur_addr;
   logic [XW-1:0]   w_clamp_x;
   logic [YW-1:0]   w_clamp_y;

   // Attribute word with the character index field replaced.
   function automatic logic [AW-1:0] f_cell(input logic [AW-1:0] attr,
                                            input logic [7:0] ch);
      logic [AW-1:0] v;
      v = attr;
      v[`CHARATTR_INDEX] = IW'(ch);
      return v;
   endfunction

   assign in_ready      = (r_state != S_CLEAR);
   assign w_accept      = in_valid && (r_state != S_CLEAR);
   assign w_cur_addr    = 16'(r_y) * 16'(COLS) + 16'(r_x);
   assign w_clamp_x     = (32'(in_data) > 32'(COLS - 1)) ? X_MAX : XW'(in_data);
   assign w_clamp_y     = (32'(in_data) > 32'(ROWS - 1)) ? Y_MAX : YW'(in_data);

   assign xcursor       = r_x;
   assign ycursor       = r_y;
   assign video_write   = r_wr;
   assign video_address = r_addr;
   assign video_value   = r_val;
   assign video_mask    = r_mask;

   // State and datapath registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_x      <= '0;
         r_y      <= '0;
         r_goto_x <= '0;
         r_attr   <= ATTR_RESET;
         r_shadow <= 16'd0;
         r_clr    <= 16'd0;
         r_wr     <= 1'b0;
         r_addr   <= 16'd0;
         r_val    <= '0;
         r_mask   <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_x      <= w_x_nxt;
         r_y      <= w_y_nxt;
         r_goto_x <= w_goto_x_nxt;
         r_attr   <= w_attr_nxt;
         r_shadow <= w_shadow_nxt;
         r_clr    <= w_clr_nxt;
         r_wr     <= w_wr_nxt;
         r_addr   <= w_addr_nxt;
         r_val    <= w_val_nxt;
         r_mask   <= w_mask_nxt;
      end
   end

   // Next-state, cursor, attribute and write-port logic.
   always_comb begin
      w_state_nxt  = r_state;
      w_x_nxt      = r_x;
      w_y_nxt      = r_y;
      w_goto_x_nxt = r_goto_x;
      w_attr_nxt   = r_attr;
      w_shadow_nxt = r_shadow;
      w_clr_nxt    = r_clr;
      w_wr_nxt     = 1'b0;
      w_addr_nxt   = r_addr;
      w_val_nxt    = r_val;
      w_mask_nxt   = r_mask;

      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               if (in_data >= 8'h20) begin
                  w_wr_nxt   = 1'b1;
                  w_addr_nxt = w_cur_addr;
                  w_val_nxt  = f_cell(r_attr, in_data);
                  w_mask_nxt = '1;
                  if (r_x == X_MAX) begin
                     w_x_nxt = '0;
                     w_y_nxt = (r_y == Y_MAX) ? '0 : r_y + YW'(1);
                  end else begin
                     w_x_nxt = r_x + XW'(1);
                  end
               end else begin
                  case (in_data)
                     8'h0D: w_x_nxt = '0;
                     8'h0A: w_y_nxt = (r_y == Y_MAX) ? '0 : r_y + YW'(1);
                     8'h08: w_x_nxt = (r_x != '0) ? r_x - XW'(1) : r_x;
                     8'h1F: w_state_nxt = S_GOTO_X;
                     8'h1B: w_state_nxt = S_ATTR2;
                     8'h0C: begin
                        // Cell 0 is written on the accepting edge itself.
                        w_state_nxt = S_CLEAR;
                        w_wr_nxt    = 1'b1;
                        w_addr_nxt  = 16'd0;
                        w_val_nxt   = f_cell(r_attr, 8'h20);
                        w_mask_nxt  = '1;
                        w_clr_nxt   = 16'd1;
                     end
                     default: w_state_nxt = S_IDLE;
                  endcase
               end
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_GOTO_X: begin
            if (w_accept) begin
               w_goto_x_nxt = w_clamp_x;
               w_state_nxt  = S_GOTO_Y;
            end else begin
               w_state_nxt = S_GOTO_X;
            end
         end
         S_GOTO_Y: begin
            if (w_accept) begin
               w_x_nxt     = r_goto_x;
               w_y_nxt     = w_clamp_y;
               w_state_nxt = S_IDLE;
            end else begin
               w_state_nxt = S_GOTO_Y;
            end
         end
         S_ATTR2: begin
            if (w_accept) begin
               w_shadow_nxt = {r_shadow[7:0], in_data};
               w_state_nxt  = S_ATTR1;
            end else begin
               w_state_nxt = S_ATTR2;
            end
         end
         S_ATTR1: begin
            if (w_accept) begin
               w_shadow_nxt = {r_shadow[7:0], in_data};
               w_state_nxt  = S_ATTR0;
            end else begin
               w_state_nxt = S_ATTR1;
            end
         end
         S_ATTR0: begin
            if (w_accept) begin
               w_attr_nxt  = AW'({r_shadow, in_data});
               w_state_nxt = S_IDLE;
            end else begin
               w_state_nxt = S_ATTR0;
            end
         end
         S_CLEAR: begin
            if (r_clr == CELLS) begin
               w_x_nxt     = '0;
               w_y_nxt     = '0;
               w_state_nxt = S_IDLE;
            end else begin
               w_wr_nxt   = 1'b1;
               w_addr_nxt = r_clr;
               w_val_nxt  = f_cell(r_attr, 8'h20);
               w_mask_nxt = '1;
               w_clr_nxt  = r_clr + 16'd1;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_text_writer.sv
// Self-checking bench for text_writer (80 columns x 4 rows, 24-bit attribute).
module tb_text_writer;

   localparam int          T_COLS = 80;
   localparam int          T_ROWS = 4;
   localparam logic [23:0] T_ATTR = 24'hA5C300;
   localparam int          T_CELLS = T_COLS * T_ROWS;

   logic        clk;
   logic        reset;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic [6:0]  xcursor;
   logic [4:0]  ycursor;
   logic        video_write;
   logic [15:0] video_address;
   logic [23:0] video_value;
   logic [23:0] video_mask;

   int tests;
   int fails;

   // Reference model: cursor, attribute and collected command parameters.
   int          mx, my;
   logic [23:0] mattr;
   logic [7:0]  mcmd;
   int          mneed;
   logic [7:0]  mprm [3];
   int          mgot;

   text_writer #(.COLS(T_COLS), .ROWS(T_ROWS), .ATTR_RESET(T_ATTR)) dut (
      .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .xcursor(xcursor), .ycursor(ycursor),
      .video_write(video_write), .video_address(video_address),
      .video_value(video_value), .video_mask(video_mask)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic model_reset();
      mx = 0; my = 0; mattr = T_ATTR; mneed = 0; mgot = 0; mcmd = 8'h00;
   endtask

   // Predict the effect of one accepted byte.
   task automatic model_step(input logic [7:0] b, output logic ew,
                             output logic [15:0] ea, output logic [23:0] ev);
      ew = 1'b0; ea = 16'd0; ev = 24'd0;
      if (mneed > 0) begin
         mprm[mgot] = b;
         mgot++;
         if (mgot == mneed) begin
            if (mcmd == 8'h1F) begin
               mx = (int'(mprm[0]) > T_COLS - 1) ? T_COLS - 1 : int'(mprm[0]);
               my = (int'(mprm[1]) > T_ROWS - 1) ? T_ROWS - 1 : int'(mprm[1]);
            end else begin
               mattr = {mprm[0], mprm[1], mprm[2]};
            end
            mneed = 0;
            mgot  = 0;
         end
      end else if (b >= 8'h20) begin
         ew = 1'b1;
         ea = 16'(my * T_COLS + mx);
         ev = {mattr[23:8], b};
         mx++;
         if (mx == T_COLS) begin
            mx = 0;
            my = (my + 1) % T_ROWS;
         end
      end else if (b == 8'h0D) begin
         mx = 0;
      end else if (b == 8'h0A) begin
         my = (my + 1) % T_ROWS;
      end else if (b == 8'h08) begin
         if (mx > 0) mx--;
      end else if (b == 8'h1F) begin
         mcmd = b; mneed = 2; mgot = 0;
      end else if (b == 8'h1B) begin
         mcmd = b; mneed = 3; mgot = 0;
      end else if (b == 8'h0C) begin
         ew = 1'b1;
         ea = 16'd0;
         ev = {mattr[23:8], 8'h20};
      end
   endtask

   // Offer one byte, wait for acceptance, then check the outcome of that edge.
   task automatic send(input logic [7:0] b);
      int guard;
      logic ew;
      logic [15:0] ea;
      logic [23:0] ev;
      @(negedge clk);
      in_data  = b;
      in_valid = 1'b1;
      guard = 0;
      while (!in_ready && guard < 2000) begin
         @(negedge clk);
         guard++;
      end
      if (!in_ready) begin
         tests++; fails++;
         $display("FAIL send_timeout: in_ready stuck at %b, want 1", in_ready);
         in_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      model_step(b, ew, ea, ev);
      tests++;
      if (video_write !== ew) begin
         fails++;
         $display("FAIL write_strobe byte %02h: got %b want %b", b, video_write, ew);
      end
      if (ew) begin
         tests++;
         if (video_address !== ea) begin
            fails++;
            $display("FAIL address byte %02h: got %0d want %0d", b, video_address, ea);
         end
         tests++;
         if (video_value !== ev) begin
            fails++;
            $display("FAIL value byte %02h: got %06h want %06h", b, video_value, ev);
         end
         tests++;
         if (video_mask !== 24'hFFFFFF) begin
            fails++;
            $display("FAIL mask: got %06h want ffffff", video_mask);
         end
      end
      tests++;
      if (int'(xcursor) !== mx || int'(ycursor) !== my) begin
         fails++;
         $display("FAIL cursor byte %02h: got (%0d,%0d) want (%0d,%0d)",
                  b, xcursor, ycursor, mx, my);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      tests++;
      if (video_write !== 1'b0 || video_address !== 16'd0 || video_value !== 24'd0 ||
          video_mask !== 24'd0 || in_ready !== 1'b1 || xcursor !== 7'd0 || ycursor !== 5'd0) begin
         fails++;
         $display("FAIL %s: got wr=%b addr=%0d val=%06h mask=%06h rdy=%b cur=(%0d,%0d) want all zero, rdy=1",
                  tag, video_write, video_address, video_value, video_mask, in_ready, xcursor, ycursor);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; in_valid = 1'b0; in_data = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset_state");
      @(negedge clk);
      reset = 1'b0;
      model_reset();
   endtask

   task automatic test_print_ab();
      send(8'h41);
      send(8'h42);
      tests++;
      if (video_address !== 16'd1 || video_value[7:0] !== 8'h42) begin
         fails++;
         $display("FAIL ab_second: got addr %0d idx %02h want 1 42", video_address, video_value[7:0]);
      end
      tests++;
      if (xcursor !== 7'd2 || ycursor !== 5'd0) begin
         fails++;
         $display("FAIL ab_cursor: got (%0d,%0d) want (2,0)", xcursor, ycursor);
      end
      @(posedge clk); #1;
      tests++;
      if (video_write !== 1'b0 || video_address !== 16'd1) begin
         fails++;
         $display("FAIL idle_after_write: got wr=%b addr=%0d want 0 1", video_write, video_address);
      end
   endtask

   task automatic test_goto();
      send(8'h1F); send(8'd5);
      tests++;
      if (xcursor !== 7'd2 || ycursor !== 5'd0) begin
         fails++;
         $display("FAIL goto_partial: got (%0d,%0d) want (2,0)", xcursor, ycursor);
      end
      send(8'd3); send(8'h5A);
      tests++;
      if (video_address !== 16'd245) begin
         fails++;
         $display("FAIL goto_addr: got %0d want 245", video_address);
      end
      send(8'h1F); send(8'd200); send(8'd200);
      tests++;
      if (xcursor !== 7'd79 || ycursor !== 5'd3) begin
         fails++;
         $display("FAIL goto_clamp: got (%0d,%0d) want (79,3)", xcursor, ycursor);
      end
      send(8'h7E);
      tests++;
      if (video_address !== 16'(T_CELLS - 1) || xcursor !== 7'd0 || ycursor !== 5'd0) begin
         fails++;
         $display("FAIL last_cell_wrap: got addr %0d cur (%0d,%0d) want %0d (0,0)",
                  video_address, xcursor, ycursor, T_CELLS - 1);
      end
   endtask

   task automatic test_attr();
      send(8'h1B); send(8'h12); send(8'h34); send(8'h56); send(8'h78);
      tests++;
      if (video_value !== 24'h123478) begin
         fails++;
         $display("FAIL attr_load: got %06h want 123478", video_value);
      end
   endtask

   task automatic test_control();
      send(8'h1F); send(8'd3); send(8'd1);
      send(8'h0D);
      send(8'h0A);
      send(8'h08);
      tests++;
      if (xcursor !== 7'd0 || ycursor !== 5'd2) begin
         fails++;
         $display("FAIL control_codes: got (%0d,%0d) want (0,2)", xcursor, ycursor);
      end
   endtask

   task automatic test_clear();
      int low_cycles;
      send(8'h0C);
      low_cycles = (in_ready === 1'b0) ? 1 : 0;
      @(negedge clk);
      in_data  = 8'h51;
      in_valid = 1'b1;
      for (int n = 1; n < T_CELLS; n++) begin
         @(posedge clk); #1;
         if (in_ready === 1'b0) low_cycles++;
         tests++;
         if (video_write !== 1'b1 || video_address !== 16'(n) ||
             video_value !== {mattr[23:8], 8'h20}) begin
            fails++;
            $display("FAIL clear_cell %0d: got wr=%b addr=%0d val=%06h want 1 %0d %06h",
                     n, video_write, video_address, video_value, n, {mattr[23:8], 8'h20});
         end
      end
      @(posedge clk); #1;
      mx = 0; my = 0;
      tests++;
      if (video_write !== 1'b0 || in_ready !== 1'b1 || xcursor !== 7'd0 || ycursor !== 5'd0) begin
         fails++;
         $display("FAIL clear_done: got wr=%b rdy=%b cur=(%0d,%0d) want 0 1 (0,0)",
                  video_write, in_ready, xcursor, ycursor);
      end
      tests++;
      if (low_cycles !== T_CELLS) begin
         fails++;
         $display("FAIL clear_ready_low: got %0d cycles want %0d", low_cycles, T_CELLS);
      end
      // The held byte is taken on the following edge.
      @(posedge clk); #1;
      in_valid = 1'b0;
      tests++;
      if (video_write !== 1'b1 || video_address !== 16'd0 || video_value[7:0] !== 8'h51) begin
         fails++;
         $display("FAIL held_byte: got wr=%b addr=%0d idx=%02h want 1 0 51",
                  video_write, video_address, video_value[7:0]);
      end
      mx = 1;
   endtask

   task automatic test_random();
      logic [7:0] ctl [6];
      logic [7:0] b;
      ctl = '{8'h0D, 8'h0A, 8'h08, 8'h1F, 8'h1B, 8'h03};
      for (int i = 0; i < 120; i++) begin
         if ($urandom_range(0, 9) < 6) b = 8'($urandom_range(32, 255));
         else if ($urandom_range(0, 3) == 0) b = 8'($urandom_range(0, 255));
         else b = ctl[$urandom_range(0, 5)];
         if (mneed == 0 && b == 8'h0C) b = 8'h0D;
         send(b);
      end
   endtask

   task automatic test_async_reset();
      send(8'h0C);
      repeat (3) @(posedge clk);
      #3;
      reset = 1'b1;
      #1;
      check_reset_outputs("reset_mid_clear");
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      send(8'h1B); send(8'h11);
      #2;
      reset = 1'b1;
      #1;
      check_reset_outputs("reset_mid_attr1");
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      send(8'h41);
      tests++;
      if (video_address !== 16'd0 || video_value !== 24'hA5C341) begin
         fails++;
         $display("FAIL post_reset_write: got addr %0d val %06h want 0 a5c341",
                  video_address, video_value);
      end
   endtask

   initial begin
      tests = 0;
      fails = 0;
      model_reset();
      test_reset();
      test_print_ab();
      test_goto();
      test_attr();
      test_control();
      test_clear();
      test_random();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/text_writer.md
# text_writer

Byte-stream text command engine sitting directly upstream of the video memory's external write port. It accepts a stream of 8-bit character and control codes over a valid/ready handshake and maintains a text cursor and a current attribute word. It turns each printable byte into a single-cycle masked write of one character cell (`video_write`/`video_address`/`video_value`/`video_mask`). It also provides cursor positioning, attribute loading and a full-screen clear sequencer.

## Interface
- `COLS`, default `` `TEXTCOLS_CHAR ``: columns per text row.
- `ROWS`, default `` `TEXTROWS_CHAR ``: text rows.
- `ATTR_RESET`, default 0: attribute word loaded at reset, `` `CHARATTR_RANGE `` wide.

- `clk` input 1: system clock. One clock domain.
- `reset` input 1: asynchronous, active-high reset.
- `in_data` input 8: command or character byte.
- `in_valid` input 1: `in_data` is valid.
- `in_ready` output 1: block can accept a byte. A byte transfers on a rising edge where `in_valid` and `in_ready` are both high.
- `xcursor` output `` `TEXTCOLS_RANGE ``: current cursor column.
- `ycursor` output `` `TEXTROWS_RANGE ``: current cursor row.
- `video_write` output 1: one-cycle write strobe.
- `video_address` output 16: cell index, `y*COLS + x`.
- `video_value` output `` `CHARATTR_RANGE ``: cell word.
- `video_mask` output `` `CHARATTR_RANGE ``: bits to update. All ones for every write this block issues.

## Operation
- FSM states: IDLE, GOTO_X, GOTO_Y, ATTR2, ATTR1, ATTR0, CLEAR.
- `in_ready` is 1 in every state except CLEAR.
- Bytes accepted in IDLE:
  - 0x20–0xFF (printable): write `in_data` at the cursor and advance the cursor.
    - Cell word = attribute register with the `` `CHARATTR_INDEX `` field replaced by `in_data`, zero-extended.
    - Advance: `x+1`. When `x` is `COLS-1`, set `x=0` and `y+1`. When `y` is `ROWS-1`, `y` wraps to 0. There is no scrolling.
  - 0x0D (CR): `x=0`.
  - 0x0A (LF): `y+1`, wrapping to 0 after `ROWS-1`. `x` is unchanged.
  - 0x08 (BS): `x-1` if `x>0`, otherwise no effect. Nothing is written.
  - 0x1F: go to GOTO_X.
    - The next byte is stored as the new column, clamped to `COLS-1`.
    - GOTO_Y: the next byte is stored as the new row, clamped to `ROWS-1`. Return to IDLE.
    - Cursor registers change only when GOTO_Y completes.
  - 0x1B: go to ATTR2.
    - Load 3 bytes, MSB first, into a shadow register.
    - The attribute register is replaced on the ATTR0 byte only. The index field is kept but is don't-care.
  - 0x0C (FF): go to CLEAR.
    - Write cells 0 to `COLS*ROWS-1` in ascending order, one per cycle.
    - Cell word = attribute with index 0x20.
    - Afterwards set the cursor to (0,0) and return to IDLE.
  - Any other byte below 0x20: ignored, but still accepted.
- In GOTO_* and ATTR* states every byte is a parameter, including 0x0C, 0x1B and 0x1F.
- Address arithmetic: 16-bit. `video_address = y*COLS + x`. The implementation may keep a row-base register instead of a multiplier. Results must be identical.
- Reset (asynchronous, any time, including mid-CLEAR or mid-sequence):
  - state IDLE; cursor (0,0); attribute = `ATTR_RESET`.
  - `video_write=0`, `video_address=0`, `video_value=0`, `video_mask=0`.
  - `in_ready=1`.
  - A partial clear is abandoned and is not resumed.

## Timing
- All `video_*` outputs are registered.
- A printable byte accepted at edge k gives `video_write=1` in the cycle after edge k, with the pre-advance cursor address. `xcursor`/`ycursor` show the advanced value after the same edge k.
- Back-to-back printable bytes, one per cycle, give back-to-back write strobes with no bubbles.
- `video_write` is low in every cycle not listed in this section. Address, value and mask hold their last values.
- FF accepted at edge k:
  - `in_ready` falls after edge k.
  - Write strobes for address n appear after edge k+n, for n = 0 to `COLS*ROWS-1`.
  - After edge k+`COLS*ROWS`: `in_ready=1`, cursor (0,0), `video_write=0`.
  - `in_valid` during CLEAR is not consumed. The sender must hold its data.
- Control, GOTO and ATTR bytes take 1 cycle each and produce no write.
- An attribute change at edge k applies to a printable byte accepted at edge k+1.

## Test plan
- After reset, send 'A','B' (0x41, 0x42) on consecutive cycles -> `video_write` pulses at addresses 0 and 1. Index fields are 0x41 and 0x42. Mask is all ones. Cursor ends at (2,0).
- Send 0x1F,5,3 then 'Z' with `COLS=80` -> write at address 245, cursor (6,3). Send 0x1F,200,200 -> cursor (`COLS-1`,`ROWS-1`). A following printable byte writes the last cell and the cursor wraps to (0,0).
- Send 0x1B,0x12,0x34,0x56 then 'x' -> `video_value` equals 0x123456 with the index field replaced by 0x78.
- Send 0x0C with `COLS=4`, `ROWS=2` -> 8 consecutive writes at addresses 0–7 with index 0x20. `in_ready` is low for exactly 8 cycles. Bytes held on `in_valid` are accepted only afterwards. Cursor is (0,0).
- Cursor (3,1): send CR, then LF, then BS at x=0 -> cursor (0,1), then (0,2), then (0,2). No writes occur.
- Assert `reset` mid-CLEAR and mid-ATTR1 -> all outputs take their reset values immediately. A subsequent 'A' writes address 0 with `ATTR_RESET`.
